// File: rtl/uart_cmd_assembler.sv
// Assembles BYTES received bytes into one command word and holds it until the
// command processor releases it; stale partial commands are dropped after TIMEOUT idle cycles.
module uart_cmd_assembler #(
  parameter int BYTES     = 2,
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       rx_data,
  input  logic                    rx_rdy,
  output logic                    clr_rx_rdy,
  input  logic                    clr_cmd_rdy,
  output logic [BYTES*DATA_W-1:0] cmd,
  output logic                    cmd_rdy,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    dbg_state
);

  localparam int W     = BYTES * DATA_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_timer;
  logic [W-1:0]     r_cmd;
  logic [W-1:0]     w_cmd_shift;
  logic             r_cmd_rdy;
  logic             r_timeout_err;
  logic             w_accept;
  logic             w_complete;
  logic             w_timeout_hit;

  // Handshakes: a byte transfers on every cycle where rx_rdy and clr_rx_rdy are both
  // high; a command is offered while cmd_rdy is high and consumed by one clr_cmd_rdy pulse.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_COLLECT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_complete)  w_state_next = ST_HOLD;
      ST_HOLD:    if (clr_cmd_rdy) w_state_next = ST_COLLECT;
      default:                     w_state_next = ST_COLLECT;
    endcase
  end

  // A clear arriving with a byte restarts the command, so that byte counts as byte 0.
  always_comb begin
    w_accept      = rx_rdy && (r_state == ST_COLLECT) && !rst;
    w_complete    = w_accept && (clr_cmd_rdy ? (BYTES == 1) : (r_cnt == CNT_LAST));
    w_timeout_hit = (TIMEOUT > 0) && (r_state == ST_COLLECT) && (r_cnt != '0) &&
                    !w_accept && !clr_cmd_rdy && (r_timer == TMR_LAST);
  end

  generate
    if (BYTES == 1) begin : g_one
      assign w_cmd_shift = rx_data;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign w_cmd_shift = {r_cmd[W-DATA_W-1:0], rx_data};
    end else begin : g_lsb
      assign w_cmd_shift = {rx_data, r_cmd[W-1:DATA_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_timer       <= '0;
      r_cmd         <= '0;
      r_cmd_rdy     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_hit;
      if (w_accept) begin
        r_cmd   <= w_cmd_shift;
        r_timer <= '0;
        if (w_complete) begin
          r_cnt     <= '0;
          r_cmd_rdy <= 1'b1;
        end else if (clr_cmd_rdy) begin
          r_cnt <= CNT_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if ((r_state == ST_COLLECT) && clr_cmd_rdy) begin
        r_cnt   <= '0;
        r_timer <= '0;
      end else if (w_timeout_hit) begin
        r_cnt   <= '0;
        r_timer <= '0;
      end else if ((TIMEOUT > 0) && (r_state == ST_COLLECT) && (r_cnt != '0)) begin
        r_timer <= r_timer + TMR_W'(1);
      end else begin
        r_timer <= '0;
      end
      if ((r_state == ST_HOLD) && clr_cmd_rdy) r_cmd_rdy <= 1'b0;
    end
  end

  assign clr_rx_rdy  = w_accept;
  assign cmd         = r_cmd;
  assign cmd_rdy     = r_cmd_rdy;
  assign busy        = (r_cnt != '0);
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule
